uarthum_rx: RTL

UART receiver: the receive-direction counterpart of the `uarthum` transmitter. Deserializes an 8N1 asynchronous serial line into bytes. It uses mid-bit sampling timed by a per-bit clock count, and filters out false start bits. Each good byte is reported with a one-cycle valid strobe, and a bad stop bit raises a framing-error strobe. It sits between the board RX pin and the byte-level command logic, and shares the `CLKS_PER_BIT` setting with `uarthum`.

---
 rtl/uarthum_rx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uarthum_rx.sv
// uarthum_rx: 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling and false-start rejection.
// Latency: o_Rx_DV/o_Frame_Err rise 9*CLKS_PER_BIT + HALF + 4 cycles after the start-bit falling edge.
// Backpressure: none; each good byte is strobed once and held on o_Rx_Byte until the next good byte.
module uarthum_rx #(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Active,
   output logic       o_Frame_Err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_HALF = CW'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_CLEANUP,
      S_BREAK
   } state_t;

   state_t        r_state, w_state_nxt;
   logic          r_sync1, r_rx_s;
   logic [CW-1:0] r_clk_cnt, w_clk_cnt_nxt;
   logic [2:0]    r_bit_idx, w_bit_idx_nxt;
   logic [7:0]    r_shift, w_shift_nxt;
   logic [7:0]    r_byte, w_byte_nxt;
   logic          r_dv, w_dv_nxt;
   logic          r_ferr, w_ferr_nxt;
   logic          r_active, w_active_nxt;
   logic          w_cnt_last, w_cnt_half;

   assign w_cnt_last = (r_clk_cnt == C_LAST);
   assign w_cnt_half = (r_clk_cnt == C_HALF);

   // Two-flop synchronizer; idles high so reset never looks like a start edge.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_sync1 <= i_Rx_Serial;
         r_rx_s  <= r_sync1;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_state   <= S_IDLE;
         r_clk_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_byte    <= '0;
         r_dv      <= 1'b0;
         r_ferr    <= 1'b0;
         r_active  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_clk_cnt <= w_clk_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_byte    <= w_byte_nxt;
         r_dv      <= w_dv_nxt;
         r_ferr    <= w_ferr_nxt;
         r_active  <= w_active_nxt;
      end
   end

   // Next-state logic: counter restarts on every state change and after every sampled bit.
   always_comb begin
      w_state_nxt   = r_state;
      w_clk_cnt_nxt = r_clk_cnt;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_byte_nxt    = r_byte;
      w_dv_nxt      = 1'b0;
      w_ferr_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_clk_cnt_nxt = '0;
            w_bit_idx_nxt = '0;
            if (!r_rx_s) w_state_nxt = S_START;
         end
         S_START: begin
            if (w_cnt_half) begin
               // Still low at mid start bit: real frame. High again: glitch, drop silently.
               w_clk_cnt_nxt = '0;
               w_bit_idx_nxt = '0;
               w_state_nxt   = r_rx_s ? S_IDLE : S_DATA;
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (w_cnt_last) begin
               w_clk_cnt_nxt          = '0;
               w_shift_nxt[r_bit_idx] = r_rx_s;
               if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
               else                   w_bit_idx_nxt = r_bit_idx + 1'b1;
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end
         S_STOP: begin
            if (w_cnt_last) begin
               w_clk_cnt_nxt = '0;
               if (r_rx_s) begin
                  w_byte_nxt  = r_shift;
                  w_dv_nxt    = 1'b1;
                  w_state_nxt = S_CLEANUP;
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = S_BREAK;
               end
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end
         S_CLEANUP: begin
            w_clk_cnt_nxt = '0;
            w_state_nxt   = S_IDLE;
         end
         S_BREAK: begin
            // A line held low after a bad stop bit must go high before a new start is accepted.
            w_clk_cnt_nxt = '0;
            if (r_rx_s) w_state_nxt = S_IDLE;
         end
         default: begin
            w_clk_cnt_nxt = '0;
            w_state_nxt   = S_IDLE;
         end
      endcase
      // Active lags START entry by one cycle and drops with the stop decision or glitch reject.
      w_active_nxt = (r_state != S_IDLE) &&
                     ((w_state_nxt == S_START) || (w_state_nxt == S_DATA) || (w_state_nxt == S_STOP));
   end

   assign o_Rx_DV     = r_dv;
   assign o_Rx_Byte   = r_byte;
   assign o_Rx_Active = r_active;
   assign o_Frame_Err = r_ferr;

endmodule
